pe_phase_sched: RTL and testbench
=================================

// Module: pe_phase_sched
// PURPOSE
//  Central phase scheduler for a PE array: sequences LOAD / COMPUTE / TRANSMIT / SHIFT / OUTPUT for all PEs in lock-step.
//  Counts iterations and exposes per-phase strobes that the PEs consume in place of their local FSMs.
//  Honours input-valid stalls during LOAD and output back-pressure during OUTPUT.
//  Sits between the host/stream interface and the PE array.
// PARAMETERS
//  LOAD_NUM   16  valid input beats per LOAD phase
//  INST_NUM   64  cycles per COMPUTE phase (one program pass)
//  TX_NUM     4   cycles per TRANSMIT phase (partial-alpha forward to next PE)
//  SHIFT_NUM  16  cycles per SHIFT phase
//  ALPHA_NUM  8   accepted output beats per OUTPUT phase
//  ITER_W     7   width of iteration count/index
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous active-high reset
//  start      in   1       begin a run; sampled only in IDLE
//  cfg_iter   in   ITER_W  iterations per run; latched on accepted start; 0 treated as 1
//  din_v      in   1       input beat valid; counted only in LOAD
//  out_ready  in   1       downstream accepts alpha beat; counted only in OUTPUT
//  load_v     out  1       high for every cycle of LOAD
//  cmpt_v     out  1       high for every cycle of COMPUTE
//  tx_v       out  1       high for every cycle of TRANSMIT
//  shift_v    out  1       high for every cycle of SHIFT
//  out_v      out  1       high for every cycle of OUTPUT (alpha valid)
//  iter_idx   out  ITER_W  current iteration, 0-based
//  last_iter  out  1       iter_idx == latched cfg_iter-1
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse after final OUTPUT beat
// BEHAVIOUR
//  - Moore FSM, states IDLE, LOAD, COMPUTE, TRANSMIT, SHIFT, OUTPUT; strobes/busy decoded from state register, so they align with the state cycle.
//  - Reset: state=IDLE, all counters 0, iter_idx=0, all outputs 0. Reset mid-run aborts immediately; no done pulse.
//  - IDLE: start=1 -> latch cfg_iter, iter_idx<=0, next LOAD. start while busy ignored.
//  - LOAD: beat counter increments on din_v=1 only; the cycle carrying the LOAD_NUM-th beat is the last LOAD cycle -> COMPUTE. din_v=0 holds LOAD indefinitely.
//  - COMPUTE: exactly INST_NUM cycles; then OUTPUT if last_iter else TRANSMIT.
//  - TRANSMIT: exactly TX_NUM cycles -> SHIFT. SHIFT: exactly SHIFT_NUM cycles -> LOAD, iter_idx += 1 on that transition.
//  - OUTPUT: beat counter increments on out_ready=1; the cycle of the ALPHA_NUM-th accepted beat is the last -> IDLE; done=1 in the next cycle (first IDLE cycle).
//  - done pulse and a new start may coincide; start is accepted in that cycle.
//  - Phase counters cleared on each phase entry; widths = clog2 of the matching parameter; no wrap beyond terminal count.
//  - iter_idx saturates at latched cfg_iter-1 (unreachable by construction; assertion target).
//  - Exactly one of load_v/cmpt_v/tx_v/shift_v/out_v high when busy; none when IDLE.
// STRUCTURE
//  - parameters.vh: LOAD_NUM, INST_NUM, TX_NUM, SHIFT_NUM, ALPHA_NUM, ITER_NUM defaults, state encodings (3-bit).
//  - One sub-module, phase_cnt: clear/enable/terminal-count counter, instanced for the beat and cycle counters; FSM and iteration register stay in this module.
// TESTING (LOAD_NUM=4, INST_NUM=8, TX_NUM=2, SHIFT_NUM=3, ALPHA_NUM=2)
//  1 cfg_iter=2, start at cycle 0, din_v=1, out_ready=1 -> LOAD 1-4, COMPUTE 5-12, TX 13-14, SHIFT 15-17, LOAD 18-21 (iter_idx=1, last_iter=1), COMPUTE 22-29, OUTPUT 30-31, done=1 at 32 only.
//  2 cfg_iter=1, din_v low 2 cycles mid-LOAD -> LOAD lasts 6 cycles, no TX/SHIFT, OUTPUT straight after COMPUTE, done once.
//  3 cfg_iter=1, out_ready toggling 1,0,0,1 in OUTPUT -> OUTPUT lasts 4 cycles, out_v held high throughout, done next cycle.
//  4 start pulses during COMPUTE and SHIFT -> no effect on sequence or latched cfg_iter; cfg_iter=0 behaves as 1.
//  5 rst asserted in TRANSMIT of iter 0 -> next cycle IDLE, all outputs 0, no done; fresh start runs a full, correct sequence.
//  6 start held high through done -> back-to-back run, LOAD begins cycle after done, iter_idx=0.

Source files
------------

// File: rtl/pe_phase_sched_pkg.sv
// pe_phase_sched shared definitions: phase defaults,
// 3-bit state codes and the strobe bundle.
package pe_phase_sched_pkg;

  localparam int LOAD_NUM_D  = 16;
  localparam int INST_NUM_D  = 64;
  localparam int TX_NUM_D    = 4;
  localparam int SHIFT_NUM_D = 16;
  localparam int ALPHA_NUM_D = 8;
  localparam int ITER_W_D    = 7;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CMPT  = 3'd2;
  localparam logic [2:0] S_TX    = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  typedef struct packed {
    logic load;
    logic cmpt;
    logic tx;
    logic shift;
    logic out;
  } phase_strb_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic phase_strb_t strb_dec(
    input logic [2:0] s
  );
    phase_strb_t r;
    r       = '0;
    r.load  = (s == S_LOAD);
    r.cmpt  = (s == S_CMPT);
    r.tx    = (s == S_TX);
    r.shift = (s == S_SHIFT);
    r.out   = (s == S_OUT);
    return r;
  endfunction

endpackage

// File: rtl/pe_phase_sched_if.sv
// Host/array side bundle of the phase scheduler:
// run control, stream handshakes and phase strobes.
interface pe_phase_sched_if #(
  parameter int ITER_W = 7
);
  logic              start;
  logic [ITER_W-1:0] cfg_iter;
  logic              din_v;
  logic              out_ready;
  logic              load_v;
  logic              cmpt_v;
  logic              tx_v;
  logic              shift_v;
  logic              out_v;
  logic [ITER_W-1:0] iter_idx;
  logic              last_iter;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_iter, din_v, out_ready,
    input  load_v, cmpt_v, tx_v, shift_v, out_v,
    input  iter_idx, last_iter, busy, done
  );

  modport slave (
    input  start, cfg_iter, din_v, out_ready,
    output load_v, cmpt_v, tx_v, shift_v, out_v,
    output iter_idx, last_iter, busy, done
  );
endinterface

// File: rtl/pe_phase_sched_phase_cnt.sv
// Clear/enable counter with terminal-count flag;
// holds at N-1 instead of wrapping.
module pe_phase_sched_phase_cnt
  import pe_phase_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = cnt_w(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && (cnt == LAST);
endmodule

// File: rtl/pe_phase_sched.sv
// Lock-step phase scheduler for the PE array:
// LOAD/COMPUTE/TRANSMIT/SHIFT/OUTPUT per iteration.
module pe_phase_sched
  import pe_phase_sched_pkg::*;
#(
  parameter int LOAD_NUM  = LOAD_NUM_D,
  parameter int INST_NUM  = INST_NUM_D,
  parameter int TX_NUM    = TX_NUM_D,
  parameter int SHIFT_NUM = SHIFT_NUM_D,
  parameter int ALPHA_NUM = ALPHA_NUM_D,
  parameter int ITER_W    = ITER_W_D
) (
  input logic clk,
  input logic rst,
  pe_phase_sched_if.slave io
);
  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [ITER_W-1:0] iter_idx;
  logic [ITER_W-1:0] iter_last;
  logic              done_q;
  logic              is_last;
  logic              busy;
  phase_strb_t       strb;

  logic load_tc, cmpt_tc, tx_tc;
  logic shift_tc, out_tc;

  assign is_last = (iter_idx == iter_last);
  assign busy    = (state != S_IDLE);
  assign strb    = strb_dec(state);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (io.start) state_nx = S_LOAD;
      S_LOAD:  if (load_tc) state_nx = S_CMPT;
      S_CMPT:
        if (cmpt_tc)
          state_nx = is_last ? S_OUT : S_TX;
      S_TX:    if (tx_tc) state_nx = S_SHIFT;
      S_SHIFT: if (shift_tc) state_nx = S_LOAD;
      S_OUT:   if (out_tc) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // each counter restarts on entry to its own phase
  pe_phase_sched_phase_cnt #(.N(LOAD_NUM)) u_load (
    .clk (clk),
    .rst (rst),
    .clr (state_nx == S_LOAD && !strb.load),
    .en  (strb.load && io.din_v),
    .tc  (load_tc)
  );

  pe_phase_sched_phase_cnt #(.N(INST_NUM)) u_cmpt (
    .clk (clk),
    .rst (rst),
    .clr (state_nx == S_CMPT && !strb.cmpt),
    .en  (strb.cmpt),
    .tc  (cmpt_tc)
  );

  pe_phase_sched_phase_cnt #(.N(TX_NUM)) u_tx (
    .clk (clk),
    .rst (rst),
    .clr (state_nx == S_TX && !strb.tx),
    .en  (strb.tx),
    .tc  (tx_tc)
  );

  pe_phase_sched_phase_cnt #(.N(SHIFT_NUM)) u_shift (
    .clk (clk),
    .rst (rst),
    .clr (state_nx == S_SHIFT && !strb.shift),
    .en  (strb.shift),
    .tc  (shift_tc)
  );

  pe_phase_sched_phase_cnt #(.N(ALPHA_NUM)) u_out (
    .clk (clk),
    .rst (rst),
    .clr (state_nx == S_OUT && !strb.out),
    .en  (strb.out && io.out_ready),
    .tc  (out_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      iter_idx  <= '0;
      iter_last <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= strb.out && out_tc;
      if (!busy && io.start) begin
        iter_idx  <= '0;
        iter_last <= (io.cfg_iter == '0) ? '0
                   : io.cfg_iter - 1'b1;
      end else if (shift_tc && !is_last) begin
        iter_idx <= iter_idx + 1'b1;
      end
    end
  end

  assign io.load_v    = strb.load;
  assign io.cmpt_v    = strb.cmpt;
  assign io.tx_v      = strb.tx;
  assign io.shift_v   = strb.shift;
  assign io.out_v     = strb.out;
  assign io.busy      = busy;
  assign io.iter_idx  = iter_idx;
  assign io.last_iter = busy && is_last;
  assign io.done      = done_q;

  a_iter_sat: assert property (
    @(posedge clk) disable iff (rst)
    iter_idx <= iter_last
  );

  a_onehot: assert property (
    @(posedge clk) disable iff (rst)
    busy ? $onehot(strb) : (strb == '0)
  );
endmodule

// File: tb/tb_pe_phase_sched.sv
// Bench for pe_phase_sched: directed runs plus random
// stimulus against a count-down phase reference model.
module tb_pe_phase_sched;
  localparam int LN = 4;
  localparam int IN = 8;
  localparam int TN = 2;
  localparam int SN = 3;
  localparam int AN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pe_phase_sched_if #(.ITER_W(7)) io ();

  pe_phase_sched #(
    .LOAD_NUM  (LN),
    .INST_NUM  (IN),
    .TX_NUM    (TN),
    .SHIFT_NUM (SN),
    .ALPHA_NUM (AN),
    .ITER_W    (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  // reference: phase 0..5 = idle,load,cmpt,tx,shift,out
  int m_ph    = 0;
  int m_left  = 0;
  int m_iter  = 0;
  int m_iters = 1;
  bit m_done  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph   = 0;
      m_iter = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_ph)
        0: if (io.start) begin
          m_iters = (io.cfg_iter == 0) ? 1
                  : int'(io.cfg_iter);
          m_iter = 0;
          m_ph   = 1;
          m_left = LN;
        end
        1: if (io.din_v) begin
          m_left--;
          if (m_left == 0) begin
            m_ph = 2; m_left = IN;
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            if (m_iter == m_iters - 1) begin
              m_ph = 5; m_left = AN;
            end else begin
              m_ph = 3; m_left = TN;
            end
          end
        end
        3: begin
          m_left--;
          if (m_left == 0) begin
            m_ph = 4; m_left = SN;
          end
        end
        4: begin
          m_left--;
          if (m_left == 0) begin
            m_ph = 1; m_left = LN; m_iter++;
          end
        end
        default: if (io.out_ready) begin
          m_left--;
          if (m_left == 0) begin
            m_ph = 0; m_done = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic check_eq(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    e = {m_ph == 1, m_ph == 2, m_ph == 3,
         m_ph == 4, m_ph == 5, m_ph != 0,
         m_ph != 0 && m_iter == m_iters - 1,
         m_done};
    check_eq("outs",
      {24'd0, io.load_v, io.cmpt_v, io.tx_v,
       io.shift_v, io.out_v, io.busy,
       io.last_iter, io.done}, {24'd0, e});
    if (m_ph != 0)
      check_eq("iter_idx", 32'(io.iter_idx), m_iter);
  endtask

  task automatic run(
    input  logic [6:0]  cfg,
    input  logic [15:0] dpat,
    input  logic [15:0] rpat,
    input  bit          poke,
    input  bit          hold,
    output int          nload,
    output int          nout,
    output int          ncyc
  );
    bit got;
    got   = 1'b0;
    nload = 0;
    nout  = 0;
    io.start     = 1'b1;
    io.cfg_iter  = cfg;
    io.din_v     = 1'b0;
    io.out_ready = 1'b0;
    step();
    ncyc = 1;
    io.start = hold;
    while (!got && ncyc < 400) begin
      io.din_v = io.load_v ? dpat[nload % 16] : 1'b0;
      io.out_ready = io.out_v ? rpat[nout % 16]
                   : 1'b0;
      if (poke) begin
        io.start = (io.cmpt_v || io.shift_v)
                 ? 1'($urandom_range(0, 1)) : 1'b0;
        io.cfg_iter = 7'($urandom);
      end
      if (io.load_v) nload++;
      if (io.out_v) nout++;
      step();
      ncyc++;
      got = io.done;
    end
    check_eq("run_done", 32'(got), 1);
  endtask

  initial begin
    int nl, no, nc;
    io.start     = 1'b0;
    io.cfg_iter  = '0;
    io.din_v     = 1'b0;
    io.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_state",
      {io.load_v, io.cmpt_v, io.tx_v, io.shift_v,
       io.out_v, io.busy, io.last_iter, io.done,
       io.iter_idx}, 0);
    step();

    run(7'd2, 16'hFFFF, 16'hFFFF, 0, 0, nl, no, nc);
    check_eq("t1_cyc", nc, 32);
    check_eq("t1_load", nl, 2 * LN);
    check_eq("t1_out", no, AN);

    run(7'd1, 16'hFFF3, 16'hFFFF, 0, 0, nl, no, nc);
    check_eq("t2_load", nl, 6);
    check_eq("t2_cyc", nc, 17);

    run(7'd1, 16'hFFFF, 16'hFFF9, 0, 0, nl, no, nc);
    check_eq("t3_out", no, 4);
    check_eq("t3_cyc", nc, 17);

    run(7'd2, 16'hFFFF, 16'hFFFF, 1, 0, nl, no, nc);
    check_eq("t4_cyc", nc, 32);
    run(7'd0, 16'hFFFF, 16'hFFFF, 1, 0, nl, no, nc);
    check_eq("t4_zero_cyc", nc, 15);

    io.start     = 1'b1;
    io.cfg_iter  = 7'd3;
    io.din_v     = 1'b1;
    io.out_ready = 1'b1;
    step();
    io.start = 1'b0;
    for (int i = 0; i < 100 && !io.tx_v; i++)
      step();
    check_eq("t5_in_tx", 32'(io.tx_v), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5_rst",
      {io.load_v, io.cmpt_v, io.tx_v, io.shift_v,
       io.out_v, io.busy, io.last_iter, io.done,
       io.iter_idx}, 0);
    repeat (3) step();
    run(7'd2, 16'hFFFF, 16'hFFFF, 0, 0, nl, no, nc);
    check_eq("t5_rerun_cyc", nc, 32);

    run(7'd1, 16'hFFFF, 16'hFFFF, 0, 1, nl, no, nc);
    check_eq("t6_cyc", nc, 15);
    step();
    check_eq("t6_load", 32'(io.load_v), 1);
    check_eq("t6_iter", 32'(io.iter_idx), 0);
    io.start = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      io.start     = ($urandom_range(0, 7) == 0);
      io.cfg_iter  = 7'($urandom_range(0, 4));
      io.din_v     = ($urandom_range(0, 2) != 0);
      io.out_ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
